program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, 16'h0000, first RAM address written.
REQ-002 Parameter TIMEOUT, 1000, max idle cycles between accepted bytes while receiving.
REQ-003 Port CLK  in  1  single clock; all state on rising edge.
REQ-004 Port RST  in  1  reset, asynchronous, active-low.
REQ-005 Port START  in  1  one-cycle request to begin a load.
REQ-006 Port RX_DATA  in  8  incoming byte.
REQ-007 Port RX_VALID  in  1  RX_DATA valid.
REQ-008 Port RX_READY  out  1  loader accepts the byte this cycle.
REQ-009 Port HALT  out  1  holds the CPU and hands the RAM port to the loader.
REQ-010 Port ADDRESS  out  16  RAM address while HALT.
REQ-011 Port DATA  out  16  word driven onto the CPU bus while HALT.
REQ-012 Port EXT_RAM_RW  out  1  RAM direction; 1 = write.
REQ-013 Port EXT_RAM_EN  out  1  RAM strobe.
REQ-014 Port BUSY  out  1  load in progress.
REQ-015 Port DONE  out  1  one-cycle pulse on successful completion.
REQ-016 Port ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 The FSM SHALL have states IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WR_SETUP, WR_STROBE, FINISH.
REQ-018 IDLE: on START=1 go to LEN_HI and assert HALT and BUSY from the next cycle; START in any other state SHALL be ignored.
REQ-019 Byte transfer SHALL occur only on RX_VALID & RX_READY; RX_READY=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO.
REQ-020 Stream format: word count N (16 bits, high byte first), then N words, each high byte first.
REQ-021 N=0 SHALL go from LEN_LO directly to FINISH with no RAM strobe.
REQ-022 After DAT_LO accept: WR_SETUP for one cycle (ADDRESS/DATA stable, EXT_RAM_RW=1, EXT_RAM_EN=0), then WR_STROBE for one cycle (EXT_RAM_EN=1).
REQ-023 Word i SHALL be written at (BASE_ADDR + i) mod 2^16, wrapping from 16'hFFFF to 16'h0000.
REQ-024 After WR_STROBE: go to DAT_HI if words remaining > 0, else FINISH.
REQ-025 FINISH SHALL last one cycle: DONE=1, HALT=0, BUSY=0, then IDLE.
REQ-026 The timeout counter SHALL reset on every accepted byte and on entry to LEN_HI; reaching TIMEOUT in a receive state SHALL pulse ERR, drop HALT/BUSY the same cycle and return to IDLE; words already written are not undone.
REQ-027 Outside WR_SETUP/WR_STROBE: EXT_RAM_EN=0, EXT_RAM_RW=0.
REQ-028 In IDLE: HALT=0, RX_READY=0, and ADDRESS/DATA hold their last values.

Reset
REQ-029 RST low SHALL immediately force IDLE, HALT=0, BUSY=0, DONE=0, ERR=0, RX_READY=0, EXT_RAM_EN=0, EXT_RAM_RW=0, ADDRESS=BASE_ADDR, DATA=0, counters=0.
REQ-030 Reset mid-load SHALL abandon the load with no further strobes; the partial byte is discarded.

Structure
REQ-031 The state encoding and the RW write-level constant SHALL live in the shared package used by the CPU controller.
REQ-032 The byte-pair-to-word assembler SHALL be one sub-module, byte_packer (16-bit shift-in, high then low).
REQ-033 Outputs SHALL be registered; no combinational path from RX_* to RAM outputs.

Verification
REQ-034 START, bytes 00 02 12 34 AB CD -> strobes at 0000=1234 and 0001=ABCD, then DONE pulse, HALT low.
REQ-035 Length 00 00 -> no EXT_RAM_EN pulse; DONE one cycle after the length is accepted.
REQ-036 BASE_ADDR=FFFF, N=2 -> writes at FFFF, then at 0000.
REQ-037 RX_VALID toggled randomly -> identical RAM writes; each write has exactly one setup and one strobe cycle.
REQ-038 Stall of TIMEOUT cycles after the first data byte -> ERR pulse, HALT=0, no strobe; a following START loads correctly.
REQ-039 RST low during WR_SETUP -> EXT_RAM_EN never asserts, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_pkg
// Purpose : Definitions shared by the program loader and the CPU controller.
//           Holds the loader FSM state encoding and the RAM direction levels.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEN_HI    = 3'd1,
    ST_LEN_LO    = 3'd2,
    ST_DAT_HI    = 3'd3,
    ST_DAT_LO    = 3'd4,
    ST_WR_SETUP  = 3'd5,
    ST_WR_STROBE = 3'd6,
    ST_FINISH    = 3'd7
  } loader_state_e;

  // EXT_RAM_RW levels seen by the RAM
  localparam logic c_RAM_RW_WRITE = 1'b1;
  localparam logic c_RAM_RW_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_if
// Purpose : Bundle of the loader's control, byte-stream and RAM/CPU bus
//           signals.
// Ports   : START, RX_DATA, RX_VALID -> loader ; RX_READY, HALT, ADDRESS,
//           DATA, EXT_RAM_RW, EXT_RAM_EN, BUSY, DONE, ERR <- loader.
//           modport master = loader side, modport slave = environment side.
// Rev     : 1.0  initial release
// ============================================================================
interface program_loader_if;

  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        HALT;
  logic [15:0] ADDRESS;
  logic [15:0] DATA;
  logic        EXT_RAM_RW;
  logic        EXT_RAM_EN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    input  START, RX_DATA, RX_VALID,
    output RX_READY, HALT, ADDRESS, DATA, EXT_RAM_RW, EXT_RAM_EN,
           BUSY, DONE, ERR
  );

  modport slave (
    output START, RX_DATA, RX_VALID,
    input  RX_READY, HALT, ADDRESS, DATA, EXT_RAM_RW, EXT_RAM_EN,
           BUSY, DONE, ERR
  );

endinterface
`default_nettype wire

// File: rtl/program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Purpose : Assembles a 16-bit word from a byte pair, high byte first.
//           word_o is the word formed by the previously shifted byte (high)
//           and the byte currently presented (low), so the caller can
//           register the complete word on the same edge the low byte is
//           accepted.
// Ports   : CLK, RST (async active-low), shift_i (accept byte_i),
//           byte_i[7:0], word_o[15:0].
// Rev     : 1.0  initial release
// ============================================================================
module byte_packer (
  input  wire logic        CLK,
  input  wire logic        RST,
  input  wire logic        shift_i,
  input  wire logic [7:0]  byte_i,
  output logic      [15:0] word_o
);

  logic [7:0] hi_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q <= 8'h00;
    end else if (shift_i) begin
      hi_q <= byte_i;
    end
  end

  assign word_o = {hi_q, byte_i};

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Purpose : Receives a length-prefixed word stream over a byte handshake,
//           halts the CPU and writes each word into RAM starting at
//           BASE_ADDR. Aborts with an ERR pulse when the stream stalls.
// Ports   : CLK, RST (async active-low), bus (program_loader_if.master):
//           START/RX_* in, RX_READY/HALT/ADDRESS/DATA/EXT_RAM_*/BUSY/DONE/
//           ERR out. All outputs are registered.
// Rev     : 1.0  initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 1000
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  program_loader_if.master bus
);

  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  loader_state_e state_q;
  logic          rx_ready_q;
  logic          halt_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          ram_en_q;
  logic          ram_rw_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic [15:0]   wr_ptr_q;
  logic [15:0]   remain_q;
  logic [TW-1:0] tmo_q;

  logic          w_accept;
  logic [15:0]   w_word;

  assign w_accept = bus.RX_VALID & rx_ready_q;

  byte_packer u_packer (
    .CLK     (CLK),
    .RST     (RST),
    .shift_i (w_accept),
    .byte_i  (bus.RX_DATA),
    .word_o  (w_word)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_rw_q   <= c_RAM_RW_READ;
      addr_q     <= BASE_ADDR;
      data_q     <= 16'h0000;
      wr_ptr_q   <= BASE_ADDR;
      remain_q   <= 16'h0000;
      tmo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            state_q    <= ST_LEN_HI;
            halt_q     <= 1'b1;
            busy_q     <= 1'b1;
            rx_ready_q <= 1'b1;
            tmo_q      <= '0;
            wr_ptr_q   <= BASE_ADDR;
          end
        end

        ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO: begin
          if (w_accept) begin
            tmo_q <= '0;
            case (state_q)
              ST_LEN_HI: state_q <= ST_LEN_LO;
              ST_LEN_LO: begin
                if (w_word == 16'h0000) begin
                  state_q    <= ST_FINISH;
                  rx_ready_q <= 1'b0;
                  halt_q     <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                end else begin
                  remain_q <= w_word;
                  state_q  <= ST_DAT_HI;
                end
              end
              ST_DAT_HI: state_q <= ST_DAT_LO;
              default: begin
                // Low data byte: latch the full word and its address so they
                // are stable for the whole setup/strobe pair.
                data_q     <= w_word;
                addr_q     <= wr_ptr_q;
                wr_ptr_q   <= wr_ptr_q + 16'd1;
                remain_q   <= remain_q - 16'd1;
                rx_ready_q <= 1'b0;
                ram_rw_q   <= c_RAM_RW_WRITE;
                state_q    <= ST_WR_SETUP;
              end
            endcase
          end else if (tmo_q == c_TMO_LAST) begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_WR_SETUP: begin
          ram_en_q <= 1'b1;
          state_q  <= ST_WR_STROBE;
        end

        ST_WR_STROBE: begin
          ram_en_q <= 1'b0;
          ram_rw_q <= c_RAM_RW_READ;
          if (remain_q != 16'h0000) begin
            state_q    <= ST_DAT_HI;
            rx_ready_q <= 1'b1;
            tmo_q      <= '0;
          end else begin
            state_q <= ST_FINISH;
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;  // ST_FINISH
      endcase
    end
  end

  assign bus.RX_READY   = rx_ready_q;
  assign bus.HALT       = halt_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.EXT_RAM_EN = ram_en_q;
  assign bus.EXT_RAM_RW = ram_rw_q;
  assign bus.ADDRESS    = addr_q;
  assign bus.DATA       = data_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Purpose : Directed self-checking bench for program_loader. Instance 0 uses
//           BASE_ADDR=0000, instance 1 uses BASE_ADDR=FFFF; both TIMEOUT=16.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_program_loader;

  localparam int c_TMO = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       sel;

  int n_checks = 0;
  int n_fail   = 0;

  program_loader_if if0 ();
  program_loader_if if1 ();

  assign if0.START    = start & ~sel;
  assign if0.RX_VALID = rx_valid & ~sel;
  assign if0.RX_DATA  = rx_data;
  assign if1.START    = start & sel;
  assign if1.RX_VALID = rx_valid & sel;
  assign if1.RX_DATA  = rx_data;

  program_loader #(.BASE_ADDR(16'h0000), .TIMEOUT(c_TMO)) u_dut0 (
    .CLK (clk), .RST (rst_n), .bus (if0)
  );
  program_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT(c_TMO)) u_dut1 (
    .CLK (clk), .RST (rst_n), .bus (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- write monitor ----------------
  logic        m_en [2], m_rw [2], m_halt [2], m_busy [2], m_done [2];
  logic [15:0] m_addr [2], m_data [2];
  logic        p_en [2], p_rw [2];
  logic [15:0] p_addr [2], p_data [2];
  int          en_cnt [2], seq_err [2], done_cnt [2];
  logic [31:0] wrq0 [$];
  logic [31:0] wrq1 [$];

  assign m_en[0] = if0.EXT_RAM_EN;  assign m_en[1] = if1.EXT_RAM_EN;
  assign m_rw[0] = if0.EXT_RAM_RW;  assign m_rw[1] = if1.EXT_RAM_RW;
  assign m_halt[0] = if0.HALT;      assign m_halt[1] = if1.HALT;
  assign m_busy[0] = if0.BUSY;      assign m_busy[1] = if1.BUSY;
  assign m_done[0] = if0.DONE;      assign m_done[1] = if1.DONE;
  assign m_addr[0] = if0.ADDRESS;   assign m_addr[1] = if1.ADDRESS;
  assign m_data[0] = if0.DATA;      assign m_data[1] = if1.DATA;

  // A strobe must follow exactly one setup cycle carrying the same
  // address/data; a setup must be followed by a strobe; DONE with HALT low.
  function automatic int mon_bad(input int k);
    int b;
    b = 0;
    if (m_en[k] && (!m_rw[k] || !m_halt[k] || p_en[k] || !p_rw[k] ||
                    p_addr[k] != m_addr[k] || p_data[k] != m_data[k])) b++;
    if (!m_en[k] && p_rw[k] && !p_en[k]) b++;
    if (m_done[k] && (m_halt[k] || m_busy[k])) b++;
    return b;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      en_cnt[k] = 0; seq_err[k] = 0; done_cnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        p_en[k] <= 1'b0;
        p_rw[k] <= 1'b0;
      end else begin
        seq_err[k]  <= seq_err[k] + mon_bad(k);
        en_cnt[k]   <= en_cnt[k] + int'(m_en[k]);
        done_cnt[k] <= done_cnt[k] + int'(m_done[k]);
        p_en[k]     <= m_en[k];
        p_rw[k]     <= m_rw[k];
        p_addr[k]   <= m_addr[k];
        p_data[k]   <= m_data[k];
      end
    end
    if (rst_n && m_en[0]) wrq0.push_back({m_addr[0], m_data[0]});
    if (rst_n && m_en[1]) wrq1.push_back({m_addr[1], m_data[1]});
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic f_ready();
    return sel ? if1.RX_READY : if0.RX_READY;
  endfunction

  function automatic logic f_done();
    return sel ? if1.DONE : if0.DONE;
  endfunction

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns at the negedge right
  // after the accepting clock edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!f_ready() && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rx_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!f_done() && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(f_done()), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t4_bytes [8];

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sel      = 1'b0;
    t4_bytes = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    repeat (3) @(negedge clk);
    check("rst_ctl0", 32'({if0.HALT, if0.BUSY, if0.DONE, if0.ERR, if0.RX_READY,
                           if0.EXT_RAM_EN, if0.EXT_RAM_RW}), 32'd0);
    check("rst_addr0", 32'(if0.ADDRESS), 32'h0000);
    check("rst_data0", 32'(if0.DATA), 32'h0000);
    check("rst_addr1", 32'(if1.ADDRESS), 32'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: two words at base 0000
    start_load();
    check("t1_halt_busy_rdy", 32'({if0.HALT, if0.BUSY, if0.RX_READY}), 32'h7);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    wait_done("t1_done");
    check("t1_done_halt_busy", 32'({if0.HALT, if0.BUSY}), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(if0.DONE), 32'd0);
    check("t1_nwr", 32'(wrq0.size()), 32'd2);
    if (wrq0.size() == 2) begin
      check("t1_w0", wrq0.pop_front(), 32'h0000_1234);
      check("t1_w1", wrq0.pop_front(), 32'h0001_ABCD);
    end
    check("t1_idle_hold", {if0.ADDRESS, if0.DATA}, 32'h0001_ABCD);

    // T2: zero-length load
    start_load();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("t2_done_now", 32'(if0.DONE), 32'd1);
    @(negedge clk);
    check("t2_done_pulse", 32'(if0.DONE), 32'd0);
    check("t2_no_strobe", 32'(en_cnt[0]), 32'd2);

    // T3: base FFFF wraps to 0000
    sel = 1'b1;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h22, 0);
    wait_done("t3_done");
    check("t3_nwr", 32'(wrq1.size()), 32'd2);
    if (wrq1.size() == 2) begin
      check("t3_w0", wrq1.pop_front(), 32'hFFFF_1111);
      check("t3_w1", wrq1.pop_front(), 32'h0000_2222);
    end
    sel = 1'b0;
    @(negedge clk);

    // T4: random valid gaps plus a START in mid-stream that must be ignored
    start_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(t4_bytes[i], int'($urandom_range(0, 3)));
      if (i == 3) start_load();
    end
    wait_done("t4_done");
    check("t4_nwr", 32'(wrq0.size()), 32'd3);
    if (wrq0.size() == 3) begin
      check("t4_w0", wrq0.pop_front(), 32'h0000_0102);
      check("t4_w1", wrq0.pop_front(), 32'h0001_0304);
      check("t4_w2", wrq0.pop_front(), 32'h0002_0506);
    end
    check("t4_seq", 32'(seq_err[0]), 32'd0);
    @(negedge clk);

    // T5: stall after the first data byte
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    repeat (c_TMO - 1) @(negedge clk);
    check("t5_no_err_early", 32'({if0.ERR, if0.HALT}), 32'h1);
    @(negedge clk);
    check("t5_err", 32'(if0.ERR), 32'd1);
    check("t5_err_ctl", 32'({if0.HALT, if0.BUSY, if0.RX_READY}), 32'd0);
    @(negedge clk);
    check("t5_err_pulse", 32'(if0.ERR), 32'd0);
    check("t5_no_strobe", 32'(en_cnt[0]), 32'd5);
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hBE, 1); send_byte(8'hEF, 2);
    wait_done("t5_reload_done");
    check("t5_nwr", 32'(wrq0.size()), 32'd1);
    if (wrq0.size() == 1) check("t5_w0", wrq0.pop_front(), 32'h0000_BEEF);
    @(negedge clk);

    // T6: asynchronous reset during WR_SETUP
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0); send_byte(8'hAA, 0);
    check("t6_in_setup", 32'({if0.EXT_RAM_RW, if0.EXT_RAM_EN}), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", 32'({if0.HALT, if0.BUSY, if0.DONE, if0.ERR, if0.RX_READY,
                             if0.EXT_RAM_EN, if0.EXT_RAM_RW}), 32'd0);
    check("t6_rst_bus", {if0.ADDRESS, if0.DATA}, 32'h0000_0000);
    repeat (3) @(negedge clk);
    check("t6_no_strobe", 32'(en_cnt[0]), 32'd6);
    rst_n = 1'b1;
    @(negedge clk);
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hC3, 0); send_byte(8'h3C, 0);
    wait_done("t6_reload_done");
    check("t6_nwr", 32'(wrq0.size()), 32'd1);
    if (wrq0.size() == 1) check("t6_w0", wrq0.pop_front(), 32'h0000_C33C);
    @(negedge clk);

    check("seq0", 32'(seq_err[0]), 32'd0);
    check("seq1", 32'(seq_err[1]), 32'd0);
    check("done_cnt0", 32'(done_cnt[0]), 32'd5);
    check("done_cnt1", 32'(done_cnt[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
